// File: rtl/enc_seq_pkg.sv
// enc_seq_pkg: shared definitions for the encoder block sequencer.
//   - enc_seq_state_e : sequencer FSM states
//   - DEF_* constants : default drain lengths, counter width, watchdog limit
//   - BLK_SIZE_*      : encoding of the blk_size input
package enc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_ENCODE = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_DONE   = 3'd5
    } enc_seq_state_e;

    // Subblock bytes drained for a 1056-bit and a 6144-bit block.
    localparam int unsigned DEF_SHORT_BYTES = 132;
    localparam int unsigned DEF_LONG_BYTES  = 768;
    localparam int unsigned DEF_CNT_W       = 10;
    localparam int unsigned DEF_WDOG_CYCLES = 16384;

    localparam logic BLK_SIZE_1056 = 1'b0;
    localparam logic BLK_SIZE_6144 = 1'b1;

endpackage

// File: rtl/enc_seq_edge_arm.sv
// enc_seq_edge_arm: turns the level blk_ready into block requests.
//   A request is a registered rising edge of blk_ready, qualified by an
//   armed flag that only re-arms once blk_ready has been seen low, so a
//   level held high never requests twice. A request that lands while the
//   sequencer is busy is parked in a one-deep pending flag; a request that
//   finds pending already set is dropped and reported on overrun.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   blk_ready     : level from the upstream FIFO writer
//   idle          : sequencer is in IDLE and will take start_req this cycle
//   start_req     : a fresh or pending request is waiting
//   overrun       : one-cycle pulse when a request is lost
module enc_seq_edge_arm (
    input  logic clk,
    input  logic rst,
    input  logic blk_ready,
    input  logic idle,
    output logic start_req,
    output logic overrun
);

    logic prev_q, prev_d;
    logic armed_q, armed_d;
    logic req_q, req_d;
    logic pending_q, pending_d;
    logic rise;

    always_comb begin
        rise      = blk_ready && !prev_q && armed_q;
        prev_d    = blk_ready;
        armed_d   = armed_q;
        req_d     = rise;
        pending_d = pending_q;
        overrun   = 1'b0;

        if (rise) begin
            armed_d = 1'b0;
        end else if (!blk_ready) begin
            armed_d = 1'b1;
        end

        if (idle) begin
            // IDLE consumes one request; if a fresh one coincides with a
            // pending one, the fresh one becomes the new pending.
            pending_d = req_q && pending_q;
        end else if (req_q) begin
            if (pending_q) begin
                overrun = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    // prev resets high so a blk_ready still high after reset is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= 1'b1;
            armed_q   <= 1'b1;
            req_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            armed_q   <= armed_d;
            req_q     <= req_d;
            pending_q <= pending_d;
        end
    end

    assign start_req = req_q || pending_q;

endmodule

// File: rtl/enc_block_sequencer.sv
// enc_block_sequencer: sequences one code block through convEncoder_bs.
//   IDLE -> START (data_valid pulse) -> ENCODE (wait computation_done)
//   -> DRAIN (rdreq_subblock under sink_ready) -> FLUSH -> DONE -> IDLE.
// Optional macro ENC_SEQ_WATCHDOG_EN adds an ENCODE watchdog of WDOG_CYCLES
// cycles that pulses timeout and abandons the block; without it timeout=0.
// Handshake: rdreq_subblock is issued only in a cycle where sink_ready is
//   high; the encoder returns the q0/q1/q2 triple one cycle later, flagged by
//   out_valid, and the sink must take it in that cycle.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   blk_ready           : upstream block available (level)
//   blk_size, tail_byte_in : block configuration, sampled on acceptance
//   computation_done    : encoder finished
//   sink_ready          : downstream can take one triple this cycle
//   data_valid          : encoder start pulse
//   code_block_length, tail_byte : latched configuration
//   rdreq_subblock, out_valid    : subblock read strobe and its data valid
//   busy, block_done, overrun, timeout : status
//   state_dbg           : current FSM state for observation
module enc_block_sequencer
    import enc_seq_pkg::*;
#(
    parameter int unsigned SHORT_BYTES = DEF_SHORT_BYTES,
    parameter int unsigned LONG_BYTES  = DEF_LONG_BYTES,
    parameter int unsigned CNT_W       = DEF_CNT_W
`ifdef ENC_SEQ_WATCHDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
`endif
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           blk_ready,
    input  logic           blk_size,
    input  logic [7:0]     tail_byte_in,
    input  logic           computation_done,
    input  logic           sink_ready,
    output logic           data_valid,
    output logic           code_block_length,
    output logic [7:0]     tail_byte,
    output logic           rdreq_subblock,
    output logic           out_valid,
    output logic           busy,
    output logic           block_done,
    output logic           overrun,
    output logic           timeout,
    output enc_seq_state_e state_dbg
);

    enc_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cbl_q, cbl_d;
    logic [7:0]       tail_q, tail_d;
    logic             out_valid_q, out_valid_d;
    logic             start_req;
    logic             wdog_hit;

    enc_seq_edge_arm u_edge_arm (
        .clk       (clk),
        .rst       (reset),
        .blk_ready (blk_ready),
        .idle      (state_q == ST_IDLE),
        .start_req (start_req),
        .overrun   (overrun)
    );

`ifdef ENC_SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;

    // Counts cycles spent in ENCODE; zero on the first ENCODE cycle.
    always_comb begin
        wdog_d = '0;
        if (state_q == ST_ENCODE) begin
            wdog_d = wdog_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign wdog_hit = (wdog_q == WD_W'(WDOG_CYCLES - 1));
`else
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cbl_d          = cbl_q;
        tail_d         = tail_q;
        data_valid     = 1'b0;
        rdreq_subblock = 1'b0;
        block_done     = 1'b0;
        timeout        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    cbl_d   = blk_size;
                    tail_d  = tail_byte_in;
                    cnt_d   = (blk_size == BLK_SIZE_6144) ? CNT_W'(LONG_BYTES)
                                                          : CNT_W'(SHORT_BYTES);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                data_valid = 1'b1;
                state_d    = ST_ENCODE;
            end
            ST_ENCODE: begin
                if (computation_done) begin
                    state_d = ST_DRAIN;
                end else if (wdog_hit) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (sink_ready && (cnt_q != '0)) begin
                    rdreq_subblock = 1'b1;
                    cnt_d          = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            // The last read's data appears during FLUSH.
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE: begin
                block_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid_d = rdreq_subblock;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cbl_q       <= 1'b0;
            tail_q      <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cbl_q       <= cbl_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign code_block_length = cbl_q;
    assign tail_byte         = tail_q;
    assign out_valid         = out_valid_q;
    assign busy              = (state_q != ST_IDLE);
    assign state_dbg         = state_q;

endmodule

// File: doc/enc_block_sequencer.md
Name: enc_block_sequencer

Overview:
Control FSM that sequences one code block through the convolutional encoder (convEncoder_bs).
- Detects a new block from the upstream input FIFO.
- Latches the block configuration and pulses the encoder's data_valid.
- Waits for computation_done, then drains the three subblock streams (q0/q1/q2) via rdreq_subblock under downstream back-pressure.
- Replaces the ad-hoc blk_ready edge/counter logic in the top level.

Parameters:
SHORT_BYTES, 132, subblock bytes to drain for a 1056-bit block (blk_size=0)
LONG_BYTES, 768, subblock bytes to drain for a 6144-bit block (blk_size=1)
CNT_W, 10, drain counter width; must hold LONG_BYTES
WDOG_CYCLES, 16384, encode watchdog limit (only with ENC_SEQ_WATCHDOG_EN)

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
blk_ready  in  1  level; upstream block fully written into the input FIFO
blk_size  in  1  0=1056-bit block, 1=6144-bit block; sampled on accepted request
tail_byte_in  in  8  tail byte; sampled on accepted request
computation_done  in  1  encoder finished; subblocks readable
sink_ready  in  1  downstream can accept one q0/q1/q2 triple this cycle
data_valid  out  1  one-cycle start pulse to encoder
code_block_length  out  1  latched blk_size to encoder
tail_byte  out  8  latched tail_byte_in to encoder
rdreq_subblock  out  1  read strobe to encoder subblock buffers
out_valid  out  1  q0/q1/q2 valid this cycle (rdreq delayed 1 cycle)
busy  out  1  high in every state except IDLE
block_done  out  1  one-cycle pulse when the last byte has been presented
overrun  out  1  one-cycle pulse when a new request is lost
timeout  out  1  one-cycle pulse on watchdog expiry (0 when feature absent)

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0, pending 0, armed 1.
- Request detection:
  - A request is a rising edge of blk_ready, qualified by the armed flag.
  - armed clears on edge acceptance and re-sets only when blk_ready is seen low.
  - A level held high never triggers twice.
- Pending flag:
  - A request arriving while busy sets pending.
  - A request arriving while pending is already set pulses overrun and is dropped.
  - Pending is serviced from IDLE on the cycle after DONE.
- States:
  - IDLE: on request or pending, latch blk_size and tail_byte_in, load counter with SHORT_BYTES or LONG_BYTES, clear pending, go to START.
  - START: data_valid=1 for exactly this cycle; go to ENCODE.
  - ENCODE: wait for computation_done (level or pulse, first high cycle); go to DRAIN. computation_done in any other state is ignored.
  - DRAIN:
    - rdreq_subblock = sink_ready && counter != 0; counter decrements on each rdreq.
    - When rdreq fires with counter==1, go to FLUSH.
    - sink_ready low stalls with no rdreq and no state change.
  - FLUSH: one cycle, letting the last out_valid appear; go to DONE.
  - DONE: block_done=1 for one cycle; go to IDLE.
- Timing:
  - out_valid is rdreq_subblock registered (one-cycle encoder read latency).
  - Exactly SHORT_BYTES or LONG_BYTES out_valid cycles occur per block.
- Latency:
  - Request edge to data_valid: 2 cycles (request registered into START).
  - computation_done to first rdreq: 1 cycle if sink_ready is high.
- code_block_length and tail_byte hold their latched values from IDLE exit until the next accepted request.
- Reset mid-operation: asynchronous return to IDLE, all outputs 0, pending cleared, armed=1. A blk_ready still high after reset is treated as a fresh edge only after it goes low then high.

Optional Feature:
ENC_SEQ_WATCHDOG_EN:
- Defined: a cycle counter runs in ENCODE. If it reaches WDOG_CYCLES without computation_done, pulse timeout, go to IDLE (no drain, no block_done); pending is kept.
- Undefined: no counter; ENCODE waits indefinitely; timeout is tied to 0.

Decomposition:
- Shared package enc_seq_pkg:
  - state enum (IDLE, START, ENCODE, DRAIN, FLUSH, DONE)
  - SHORT_BYTES/LONG_BYTES constants
  - blk_size encoding constants
- One natural sub-module, enc_seq_edge_arm: the blk_ready rising-edge detector with armed/pending/overrun logic.
- The FSM and drain counter stay in the top level.

Test Plan:
1. Reset, blk_ready 0→1, blk_size=0, tail 0xA5, computation_done 20 cycles after data_valid, sink_ready=1 → data_valid single pulse 2 cycles after edge; tail_byte=0xA5; 132 consecutive out_valid; block_done 2 cycles after the last rdreq.
2. blk_size=1 with sink_ready toggling 1,0 every cycle → exactly 768 rdreq, none while sink_ready=0; counter never underflows; code_block_length=1.
3. blk_ready held high across two blocks → only one block processed. Low then high during DRAIN → pending set, second block starts in IDLE the cycle after block_done. A third edge while pending is set → overrun pulse.
4. reset asserted mid-DRAIN after 50 reads → same-cycle outputs 0, state IDLE. No further rdreq until a new low→high blk_ready.
5. With ENC_SEQ_WATCHDOG_EN and WDOG_CYCLES=64, computation_done withheld → timeout pulse at ENCODE cycle 64, return to IDLE, no block_done. Without the macro → remains busy.
